intan_seq_ctrl: RTL and testbench

Command sequencer between the Intan configuration block and the Intan SPI master. It issues the register-setup command list once on request, then runs one conversion frame per `start` pulse: a CONVERT for each channel, followed by two pipeline-flush commands. Each returned sample is pushed into the ADC receive FIFO. The sequencer accounts for the chip's two-command result latency, so only valid samples reach the FIFO.

---
 rtl/intan_seq_ctrl_if.sv | 35 +++
 rtl/intan_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_intan_seq_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intan_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// intan_seq_ctrl_if
//
// Command/result handshake between the Intan command sequencer and the SPI
// master.
//
//   spi_req    sequencer -> SPI master   command request, held until spi_ack
//   spi_cmd    sequencer -> SPI master   command word, valid while spi_req=1
//   spi_ack    SPI master -> sequencer   one-cycle pulse: command finished
//   spi_rdata  SPI master -> sequencer   result word, valid with spi_ack
//
// master: the sequencer side.  slave: the SPI master side.
// -----------------------------------------------------------------------------
interface intan_seq_ctrl_if #(
  parameter int CMD_W = 16
);
  logic             spi_req;
  logic [CMD_W-1:0] spi_cmd;
  logic             spi_ack;
  logic [CMD_W-1:0] spi_rdata;

  modport master (
    output spi_req,
    output spi_cmd,
    input  spi_ack,
    input  spi_rdata
  );

  modport slave (
    input  spi_req,
    input  spi_cmd,
    output spi_ack,
    output spi_rdata
  );
endinterface

// File: rtl/intan_seq_ctrl.sv
// -----------------------------------------------------------------------------
// intan_seq_ctrl
//
// Command sequencer between the Intan configuration block and the SPI master.
// On init_req it sends the register-setup list (up to four words) followed by
// two dummy reads. On start it runs one conversion frame: CONVERT(0..N-1)
// followed by two dummy reads. The chip returns each result two commands
// late, so in a conversion frame acks 2..N+1 carry the N samples; only those
// are written to the ADC receive FIFO.
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   init_req     one-cycle pulse: run the setup sequence
//   start        one-cycle pulse: run one conversion frame
//   cfg_cmd      four setup words, slot k = [16k+15:16k], slot 0 sent first
//   cfg_num      setup words in use (values above 4 count as 4)
//   data_cnt     channels per frame (values above 64 count as 64)
//   spi          command/result handshake to the SPI master (master modport)
//   fifo_wr      one-cycle write strobe to the ADC receive FIFO
//   fifo_wdata   sample word, valid with fifo_wr
//   busy         high whenever the sequencer is not idle
//   init_done    set when the setup sequence completes, cleared by reset
//   frame_done   one-cycle pulse at the end of a conversion frame
// -----------------------------------------------------------------------------
module intan_seq_ctrl #(
  parameter int CMD_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_req,
  input  logic                 start,
  input  logic [4*CMD_W-1:0]   cfg_cmd,
  input  logic [2:0]           cfg_num,
  input  logic [7:0]           data_cnt,
  intan_seq_ctrl_if.master     spi,
  output logic                 fifo_wr,
  output logic [CMD_W-1:0]     fifo_wdata,
  output logic                 busy,
  output logic                 init_done,
  output logic                 frame_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;
  typedef enum logic       {PH_INIT, PH_CONV}       phase_t;

  // READ register 40: harmless command used to clock out the last two results.
  localparam logic [CMD_W-1:0] DUMMY_CMD = CMD_W'(16'hE800);

  state_t              state;
  phase_t              phase;
  logic [6:0]          cmd_idx;   // commands acknowledged so far in this phase
  logic [6:0]          n_cmd;     // real (non-dummy) commands in this phase
  logic [4*CMD_W-1:0]  cfg_q;     // setup words frozen at phase start

  logic [6:0]          init_n;
  logic [6:0]          conv_n;
  logic [6:0]          total;
  phase_t              acc_phase;
  logic [6:0]          acc_n;

  assign init_n    = (cfg_num > 3'd4)   ? 7'd4  : {4'd0, cfg_num};
  assign conv_n    = (data_cnt > 8'd64) ? 7'd64 : data_cnt[6:0];
  assign total     = n_cmd + 7'd2;
  // init_req has priority when both pulses arrive together.
  assign acc_phase = init_req ? PH_INIT : PH_CONV;
  assign acc_n     = init_req ? init_n  : conv_n;

  // Command word for position idx of a phase with n real commands.
  function automatic logic [CMD_W-1:0] cmd_word(
    input phase_t             ph,
    input logic [6:0]         idx,
    input logic [6:0]         n,
    input logic [4*CMD_W-1:0] cfg
  );
    if (idx >= n)       return DUMMY_CMD;
    if (ph == PH_INIT)  return cfg[int'(idx[1:0])*CMD_W +: CMD_W];
    return CMD_W'({2'b00, idx[5:0], 8'h00});
  endfunction

  // Every output is a register. The next command word is therefore computed
  // on the edge that raises spi_req (leaving IDLE or GAP), so spi_cmd is
  // already valid in the first cycle of the request.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase       <= PH_INIT;
      cmd_idx     <= '0;
      n_cmd       <= '0;
      cfg_q       <= '0;
      spi.spi_req <= 1'b0;
      spi.spi_cmd <= '0;
      fifo_wr     <= 1'b0;
      fifo_wdata  <= '0;
      busy        <= 1'b0;
      init_done   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (init_req || start) begin
            phase       <= acc_phase;
            n_cmd       <= acc_n;
            cfg_q       <= cfg_cmd;
            cmd_idx     <= '0;
            spi.spi_req <= 1'b1;
            spi.spi_cmd <= cmd_word(acc_phase, 7'd0, acc_n, cfg_cmd);
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          // spi_req is high throughout ISSUE, so any ack seen here is valid.
          if (spi.spi_ack) begin
            spi.spi_req <= 1'b0;
            cmd_idx     <= cmd_idx + 7'd1;
            // Acks 0 and 1 return results of commands sent before this phase.
            if (phase == PH_CONV && cmd_idx >= 7'd2) begin
              fifo_wr    <= 1'b1;
              fifo_wdata <= spi.spi_rdata;
            end
            state <= GAP;
          end
        end

        GAP: begin
          fifo_wr <= 1'b0;
          if (cmd_idx == total) begin
            if (phase == PH_CONV) frame_done <= 1'b1;
            else                  init_done  <= 1'b1;
            state <= DONE;
          end else begin
            spi.spi_req <= 1'b1;
            spi.spi_cmd <= cmd_word(phase, cmd_idx, n_cmd, cfg_q);
            state       <= ISSUE;
          end
        end

        DONE: begin
          frame_done <= 1'b0;
          cmd_idx    <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intan_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intan_seq_ctrl
//
// Bench for intan_seq_ctrl. An SPI-master responder acks each command after a
// chosen delay and can inject acks while no request is pending. A reference
// model, sampled 1 time unit after every rising edge, derives the expected
// command list from the configuration captured at acceptance and predicts
// every output from the handshake timing rules. Directed phases additionally
// compare the observed command and sample streams with literal lists.
// -----------------------------------------------------------------------------
module tb_intan_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_req;
  logic        start;
  logic [63:0] cfg_cmd;
  logic [2:0]  cfg_num;
  logic [7:0]  data_cnt;
  logic        fifo_wr;
  logic [15:0] fifo_wdata;
  logic        busy;
  logic        init_done;
  logic        frame_done;

  intan_seq_ctrl_if #(.CMD_W(16)) bus ();

  intan_seq_ctrl #(.CMD_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_req   (init_req),
    .start      (start),
    .cfg_cmd    (cfg_cmd),
    .cfg_num    (cfg_num),
    .data_cnt   (data_cnt),
    .spi        (bus),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .busy       (busy),
    .init_done  (init_done),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- responder
  int          ack_no     = 0;     // acks given in the current phase
  int          long_cmd   = -1;    // ack index that is delayed 5 cycles
  bit          rand_delay = 1'b0;
  bit          rand_rdata = 1'b0;
  bit          spur_en    = 1'b0;
  logic [15:0] rd_base    = 16'h1000;
  int          hold       = 0;

  initial begin
    bus.spi_ack   = 1'b0;
    bus.spi_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.spi_ack = 1'b0;
        hold        = 0;
      end else if (bus.spi_ack) begin
        bus.spi_ack = 1'b0;
      end else if (bus.spi_req) begin
        if (hold == 0)
          hold = (ack_no == long_cmd) ? 5 : (rand_delay ? int'($urandom_range(1, 4)) : 1);
        hold--;
        if (hold == 0) begin
          bus.spi_ack   = 1'b1;
          bus.spi_rdata = rand_rdata ? 16'($urandom) : rd_base + 16'(ack_no);
          ack_no++;
        end
      end else if (spur_en && $urandom_range(0, 2) == 0) begin
        bus.spi_ack   = 1'b1;       // no request pending: must be ignored
        bus.spi_rdata = 16'hDEAD;
      end
    end
  end

  // ------------------------------------------------------ model and compare
  logic [15:0] m_cmds[$];          // expected command list of the phase
  bit          m_busy   = 1'b0;
  bit          m_req_on = 1'b0;
  bit          m_conv   = 1'b0;
  bit          m_init   = 1'b0;    // expected init_done level
  int          m_acks   = 0;
  int          since    = 0;       // samples since the last taken ack
  logic [15:0] obs_cmds[$];        // commands seen at each spi_req rise
  logic [15:0] obs_wd[$];          // words seen with fifo_wr
  int          fd_cnt   = 0;
  bit          prev_req = 1'b0;

  initial begin : compare
    bit          exp_wr;
    bit          exp_fd;
    logic [15:0] exp_wd;
    int          n;
    forever begin
      @(posedge clk);
      #1;
      exp_wr = 1'b0;
      exp_fd = 1'b0;
      exp_wd = 16'h0;
      if (!rst_n) begin
        m_busy   = 1'b0;
        m_req_on = 1'b0;
        m_init   = 1'b0;
      end else if (!m_busy) begin
        if (init_req || start) begin
          m_cmds.delete();
          m_conv = !init_req;
          if (init_req) begin
            n = (cfg_num > 4) ? 4 : int'(cfg_num);
            for (int k = 0; k < n; k++) m_cmds.push_back(cfg_cmd[16*k +: 16]);
          end else begin
            n = (data_cnt > 64) ? 64 : int'(data_cnt);
            for (int k = 0; k < n; k++) m_cmds.push_back(16'(k * 256));
          end
          m_cmds.push_back(16'hE800);
          m_cmds.push_back(16'hE800);
          m_busy   = 1'b1;
          m_req_on = 1'b1;
          m_acks   = 0;
        end
      end else if (m_req_on) begin
        if (bus.spi_ack) begin
          exp_wr   = m_conv && (m_acks >= 2);
          exp_wd   = bus.spi_rdata;
          m_acks++;
          m_req_on = 1'b0;
          since    = 0;
        end
      end else begin
        since++;
        if (m_acks < m_cmds.size()) begin
          m_req_on = 1'b1;
        end else if (since == 1) begin
          exp_fd = m_conv;
          if (!m_conv) m_init = 1'b1;
        end else begin
          m_busy = 1'b0;
        end
      end

      if (!rst_n) begin
        check("rst_spi_req", bus.spi_req, 0);
        check("rst_spi_cmd", bus.spi_cmd, 0);
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_fifo_wdata", fifo_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_init_done", init_done, 0);
        check("rst_frame_done", frame_done, 0);
      end else begin
        check("spi_req", bus.spi_req, m_req_on);
        if (m_req_on) check("spi_cmd", bus.spi_cmd, m_cmds[m_acks]);
        check("busy", busy, m_busy);
        check("fifo_wr", fifo_wr, exp_wr);
        if (exp_wr) check("fifo_wdata", fifo_wdata, exp_wd);
        check("frame_done", frame_done, exp_fd);
        check("init_done", init_done, m_init);
      end

      if (bus.spi_req && !prev_req) obs_cmds.push_back(bus.spi_cmd);
      if (fifo_wr) obs_wd.push_back(fifo_wdata);
      if (frame_done) fd_cnt++;
      prev_req = bus.spi_req;
    end
  end

  // ------------------------------------------------------------------ driver
  bit jitter_cfg = 1'b0;           // scramble config inputs while busy

  task automatic wait_idle();
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (jitter_cfg) begin
        cfg_cmd  = {$urandom, $urandom};
        cfg_num  = 3'($urandom);
        data_cnt = 8'($urandom);
      end
    end while ((busy || m_busy) && cyc < 3000);
    check("phase_timeout", (busy || m_busy), 0);
  endtask

  task automatic run_phase(input bit do_init, input bit do_start, input bit start_during);
    obs_cmds.delete();
    obs_wd.delete();
    ack_no = 0;
    @(negedge clk);
    init_req = do_init;
    start    = do_start;
    @(negedge clk);
    init_req = 1'b0;
    start    = 1'b0;
    if (start_during) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
  endtask

  task automatic check_seq(input string name, input logic [15:0] got[$], input logic [15:0] want[$]);
    check({name, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      check($sformatf("%s[%0d]", name, i), (i < got.size()) ? {16'h0, got[i]} : 32'hFFFF_FFFF, want[i]);
  endtask

  initial begin : main
    int          fd0;
    int          cyc;
    bit          do_init;
    logic [15:0] want[$];

    rst_n    = 1'b0;
    init_req = 1'b0;
    start    = 1'b0;
    cfg_cmd  = '0;
    cfg_num  = '0;
    data_cnt = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_init_done", init_done, 0);
    rst_n = 1'b1;

    // Setup sequence with three commands.
    cfg_cmd = {16'h0000, 16'h8203, 16'h8102, 16'h8001};
    cfg_num = 3'd3;
    run_phase(1'b1, 1'b0, 1'b0);
    want = '{16'h8001, 16'h8102, 16'h8203, 16'hE800, 16'hE800};
    check_seq("init_cmds", obs_cmds, want);
    check("init_writes", obs_wd.size(), 0);
    check("init_done_set", init_done, 1);

    // Four-channel frame, rdata = 0x1000 + ack number.
    fd0      = fd_cnt;
    data_cnt = 8'd4;
    run_phase(1'b0, 1'b1, 1'b0);
    want = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'hE800, 16'hE800};
    check_seq("conv4_cmds", obs_cmds, want);
    want = '{16'h1002, 16'h1003, 16'h1004, 16'h1005};
    check_seq("conv4_data", obs_wd, want);
    check("conv4_frame_done", fd_cnt - fd0, 1);

    // Empty frame.
    fd0      = fd_cnt;
    data_cnt = 8'd0;
    run_phase(1'b0, 1'b1, 1'b0);
    want = '{16'hE800, 16'hE800};
    check_seq("conv0_cmds", obs_cmds, want);
    check("conv0_writes", obs_wd.size(), 0);
    check("conv0_frame_done", fd_cnt - fd0, 1);

    // Channel count clamped to 64.
    data_cnt = 8'd200;
    run_phase(1'b0, 1'b1, 1'b0);
    check("conv200_cmd_count", obs_cmds.size(), 66);
    check("conv200_write_count", obs_wd.size(), 64);
    if (obs_cmds.size() == 66) begin
      check("conv200_last_convert", obs_cmds[63], 16'h3F00);
      check("conv200_first_dummy", obs_cmds[64], 16'hE800);
    end
    if (obs_wd.size() == 64) begin
      check("conv200_first_word", obs_wd[0], 16'h1002);
      check("conv200_last_word", obs_wd[63], 16'h1041);
    end

    // init_req and start together, then start while busy: one INIT only.
    fd0      = fd_cnt;
    cfg_cmd  = {32'h0, 16'h8B02, 16'h8A01};
    cfg_num  = 3'd2;
    data_cnt = 8'd5;
    run_phase(1'b1, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    want = '{16'h8A01, 16'h8B02, 16'hE800, 16'hE800};
    check_seq("collide_cmds", obs_cmds, want);
    check("collide_no_frame", fd_cnt - fd0, 0);
    check("collide_idle", busy, 0);

    // Ack for command 2 held back 5 cycles; acks injected between requests.
    long_cmd = 2;
    spur_en  = 1'b1;
    rd_base  = 16'h2000;
    data_cnt = 8'd3;
    run_phase(1'b0, 1'b1, 1'b0);
    want = '{16'h0000, 16'h0100, 16'h0200, 16'hE800, 16'hE800};
    check_seq("slow_cmds", obs_cmds, want);
    want = '{16'h2002, 16'h2003, 16'h2004};
    check_seq("slow_data", obs_wd, want);

    // Randomised phases with config scrambled while busy.
    rand_delay = 1'b1;
    rand_rdata = 1'b1;
    jitter_cfg = 1'b1;
    for (int it = 0; it < 14; it++) begin
      do_init  = ($urandom_range(0, 3) == 0);
      cfg_cmd  = {$urandom, $urandom};
      cfg_num  = 3'($urandom_range(0, 7));
      data_cnt = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(65, 255)) : 8'($urandom_range(0, 70));
      spur_en  = 1'($urandom_range(0, 1));
      long_cmd = int'($urandom_range(0, 7));
      run_phase(do_init, !do_init, 1'b0);
    end
    jitter_cfg = 1'b0;
    rand_delay = 1'b0;
    rand_rdata = 1'b0;
    spur_en    = 1'b0;
    long_cmd   = -1;
    rd_base    = 16'h1000;

    // Reset in the middle of a frame, after two FIFO writes.
    obs_cmds.delete();
    obs_wd.delete();
    ack_no   = 0;
    data_cnt = 8'd8;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (obs_wd.size() < 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("midreset_two_writes", obs_wd.size(), 2);
    rst_n = 1'b0;
    #1;
    check("midreset_spi_req", bus.spi_req, 0);
    check("midreset_spi_cmd", bus.spi_cmd, 0);
    check("midreset_fifo_wr", fifo_wr, 0);
    check("midreset_fifo_wdata", fifo_wdata, 0);
    check("midreset_busy", busy, 0);
    check("midreset_init_done", init_done, 0);
    check("midreset_frame_done", frame_done, 0);
    repeat (3) @(negedge clk);
    rst_n    = 1'b1;
    data_cnt = 8'd2;
    run_phase(1'b0, 1'b1, 1'b0);
    want = '{16'h0000, 16'h0100, 16'hE800, 16'hE800};
    check_seq("after_reset_cmds", obs_cmds, want);
    want = '{16'h1002, 16'h1003};
    check_seq("after_reset_data", obs_wd, want);
    check("after_reset_init_done", init_done, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
